// File: rtl/apb_cmd_master.sv
// rtl/apb_cmd_master.sv - valid/ready command stream to APB3 initiator, one transfer in flight
// Optional completer-hang timeout: define APB_CMD_MASTER_TIMEOUT_EN.

module apb_cmd_master #(
  parameter int ADDR_W         = 12,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              pclk_i,
  input  logic              preset_n_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_slverr_o,
  output logic              rsp_timeout_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic              pwrite_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic [DATA_W-1:0] prdata_i,
  input  logic              pready_i,
  input  logic              pslverr_i,
  output logic              busy_o
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_timeout_range_bad
    $error("apb_cmd_master: TIMEOUT_CYCLES must be within 1..65535");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t state_q;
  state_t state_d;
  logic   accept;
  logic   complete;
  logic   abort;

  assign req_ready_o = (state_q == IDLE);
  assign accept      = req_valid_i && req_ready_o;
  assign complete    = (state_q == ACCESS) && pready_i;

`ifdef APB_CMD_MASTER_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wait_cnt_q;
  logic        rsp_timeout_q;

  // Abort on the TIMEOUT_CYCLES-th stalled ACCESS cycle; a ready in that cycle still wins.
  assign abort = (state_q == ACCESS) && !pready_i && (wait_cnt_q == TIMEOUT_LAST);

  always_ff @(posedge pclk_i or negedge preset_n_i) begin
    if (!preset_n_i) begin
      wait_cnt_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      if (state_q == SETUP) begin
        wait_cnt_q <= '0;
      end else if ((state_q == ACCESS) && !pready_i) begin
        wait_cnt_q <= wait_cnt_q + 16'd1;
      end
      if (complete) begin
        rsp_timeout_q <= 1'b0;
      end else if (abort) begin
        rsp_timeout_q <= 1'b1;
      end
    end
  end

  assign rsp_timeout_o = rsp_timeout_q;
`else
  assign abort         = 1'b0;
  assign rsp_timeout_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (accept) state_d = SETUP;
      SETUP:  state_d = ACCESS;
      ACCESS: if (complete || abort) state_d = RESP;
      RESP:   if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // APB and response strobes are registered from the next state so they switch with it.
  always_ff @(posedge pclk_i or negedge preset_n_i) begin
    if (!preset_n_i) begin
      state_q      <= IDLE;
      psel_o       <= 1'b0;
      penable_o    <= 1'b0;
      busy_o       <= 1'b0;
      rsp_valid_o  <= 1'b0;
      pwrite_o     <= 1'b0;
      paddr_o      <= '0;
      pwdata_o     <= '0;
      rsp_rdata_o  <= '0;
      rsp_slverr_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_o      <= (state_d == SETUP) || (state_d == ACCESS);
      penable_o   <= (state_d == ACCESS);
      busy_o      <= (state_d != IDLE);
      rsp_valid_o <= (state_d == RESP);
      if (accept) begin
        pwrite_o <= req_write_i;
        paddr_o  <= req_addr_i;
        pwdata_o <= req_wdata_i;
      end
      if (complete) begin
        rsp_slverr_o <= pslverr_i;
        rsp_rdata_o  <= pwrite_o ? '0 : prdata_i;
      end else if (abort) begin
        rsp_slverr_o <= 1'b1;
        rsp_rdata_o  <= '0;
      end
    end
  end

endmodule
